// File: rtl/sr_pkg.sv
// Shared definitions for the sr_flop_bank storage bank: S=R=1 resolution modes.
package sr_pkg;

  typedef logic [1:0] sr_mode_t;

  localparam sr_mode_t SR_MODE_SET_DOM = 2'd0;
  localparam sr_mode_t SR_MODE_RST_DOM = 2'd1;
  localparam sr_mode_t SR_MODE_HOLD    = 2'd2;
  localparam sr_mode_t SR_MODE_TOGGLE  = 2'd3;

endpackage

// File: rtl/sr_cell.sv
// One clocked SR channel with collision detect.
// When SR_EDGE_DETECT_EN is defined, s/r act only on their rising edges.
module sr_cell
  import sr_pkg::*;
#(
  parameter int MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_n,
  output logic coll
);

  localparam sr_mode_t MODE_C = sr_mode_t'(MODE);

  logic q_q, q_d;
  logic set_req, rst_req;

`ifdef SR_EDGE_DETECT_EN
  // Previous-value registers track the inputs every cycle, even with en=0,
  // so a level held across a disabled window cannot retrigger.
  logic s_prev_q, r_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev_q <= 1'b0;
      r_prev_q <= 1'b0;
    end else begin
      s_prev_q <= s;
      r_prev_q <= r;
    end
  end

  assign set_req = s & ~s_prev_q;
  assign rst_req = r & ~r_prev_q;
`else
  assign set_req = s;
  assign rst_req = r;
`endif

  always_comb begin
    q_d  = q_q;
    coll = en & set_req & rst_req;
    if (en) begin
      case ({set_req, rst_req})
        2'b10: q_d = 1'b1;
        2'b01: q_d = 1'b0;
        2'b11: begin
          case (MODE_C)
            SR_MODE_SET_DOM: q_d = 1'b1;
            SR_MODE_RST_DOM: q_d = 1'b0;
            SR_MODE_HOLD:    q_d = q_q;
            SR_MODE_TOGGLE:  q_d = ~q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  // q_n comes straight off the state flop so q and q_n can never both be 1.
  assign q   = q_q;
  assign q_n = ~q_q;

endmodule

// File: rtl/sr_flop_bank.sv
// Multi-channel clocked SR bank with sticky collision flags and a saturating
// collision counter. Optional rising-edge request mode: SR_EDGE_DETECT_EN.
module sr_flop_bank
  import sr_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int MODE     = 0,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  input  logic                clr_err,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_n,
  output logic [CHANNELS-1:0] collision,
  output logic [CNT_W-1:0]    collision_cnt
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("sr_flop_bank: CHANNELS=%0d outside 1..32", CHANNELS);
  end
  if (MODE < 0 || MODE > int'(SR_MODE_TOGGLE)) begin : g_bad_mode
    $error("sr_flop_bank: MODE=%0d is not a valid resolution mode", MODE);
  end
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("sr_flop_bank: CNT_W=%0d outside 2..16", CNT_W);
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0] coll_hit;
  logic [CHANNELS-1:0] collision_q, collision_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                any_hit;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    sr_cell #(
      .MODE(MODE)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q[i]),
      .q_n  (q_n[i]),
      .coll (coll_hit[i])
    );
  end

  // A collision in the same cycle as clr_err survives the clear.
  always_comb begin
    any_hit     = |coll_hit;
    collision_d = collision_q | coll_hit;
    cnt_d       = cnt_q;
    if (clr_err) begin
      collision_d = coll_hit;
      cnt_d       = any_hit ? CNT_ONE : '0;
    end else if (any_hit && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= '0;
      cnt_q       <= '0;
    end else begin
      collision_q <= collision_d;
      cnt_q       <= cnt_d;
    end
  end

  assign collision     = collision_q;
  assign collision_cnt = cnt_q;

endmodule
